// File: rtl/threshold_calibrator.sv
// Threshold calibrator: samples a square screen window over several frames,
// tracks per-channel min/max and commits a widened threshold set to the
// red or green target.
`timescale 1ns/1ps
module threshold_calibrator #(
    parameter logic [10:0] WIN_X0   = 11'd310,
    parameter logic [10:0] WIN_Y0   = 11'd230,
    parameter logic [10:0] WIN_SIZE = 11'd20,
    parameter logic [3:0]  FRAMES   = 4'd8,
    parameter logic [7:0]  MARGIN   = 8'd8,
    parameter logic [47:0] DEF_R    = 48'h0FFA_0891_A5F8,
    parameter logic [47:0] DEF_G    = 48'h50F3_0878_0878
) (
    input  logic        VGA_CLK,
    input  logic        RESET,
    input  logic [10:0] VGA_X,
    input  logic [10:0] VGA_Y,
    input  logic [9:0]  C1,
    input  logic [9:0]  C2,
    input  logic [9:0]  C3,
    input  logic        iCalStart,
    input  logic        iCalSel,
    input  logic        iCalAbort,
    output logic [47:0] oThreshR,
    output logic [47:0] oThreshG,
    output logic        oBusy,
    output logic        oDone,
    output logic        oError,
    output logic        oInWindow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_FRAME,
        S_ACCUM,
        S_COMMIT
    } state_t;

    localparam logic [10:0] WIN_X1 = WIN_X0 + WIN_SIZE - 11'd1;
    localparam logic [10:0] WIN_Y1 = WIN_Y0 + WIN_SIZE - 11'd1;
    localparam logic [7:0]  HI_LIMIT = 8'd255 - MARGIN;

    state_t      state_q, state_d;
    logic        tgt_q, tgt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  min_q [3];
    logic [7:0]  min_d [3];
    logic [7:0]  max_q [3];
    logic [7:0]  max_d [3];
    logic [47:0] thr_r_q, thr_r_d;
    logic [47:0] thr_g_q, thr_g_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        marker;
    logic        in_win;
    logic [7:0]  pix [3];
    logic [7:0]  low [3];
    logic [7:0]  high [3];
    logic        empty;
    logic [47:0] new_set;
    logic        unused_low_bits;

    // Window decode, frame marker and 8-bit pixel extraction
    always_comb begin
        marker = (VGA_X == 11'd1) && (VGA_Y == 11'd1);
        in_win = (VGA_X >= WIN_X0) && (VGA_X <= WIN_X1) &&
                 (VGA_Y >= WIN_Y0) && (VGA_Y <= WIN_Y1);
        pix[0] = C1[9:2];
        pix[1] = C2[9:2];
        pix[2] = C3[9:2];
    end

    assign unused_low_bits = ^{C1[1:0], C2[1:0], C3[1:0]};
    assign oInWindow = in_win;

    // Saturating widening of the observed range and empty-window detect
    always_comb begin
        empty = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            low[i]  = (min_q[i] > MARGIN)   ? min_q[i] - MARGIN : 8'd0;
            high[i] = (max_q[i] < HI_LIMIT) ? max_q[i] + MARGIN : 8'd255;
            if (min_q[i] > max_q[i]) begin
                empty = 1'b1;
            end
        end
        new_set = {low[0], high[0], low[1], high[1], low[2], high[2]};
    end

    // Next-state, accumulation and commit logic; abort wins over everything
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        min_d   = min_q;
        max_d   = max_q;
        thr_r_d = thr_r_q;
        thr_g_d = thr_g_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iCalStart && !iCalAbort) begin
                    state_d = S_WAIT_FRAME;
                    tgt_d   = iCalSel;
                end
            end
            S_WAIT_FRAME: begin
                if (iCalAbort) begin
                    state_d = S_IDLE;
                end else if (marker) begin
                    state_d = S_ACCUM;
                    cnt_d   = '0;
                    for (int unsigned i = 0; i < 3; i++) begin
                        min_d[i] = '1;
                        max_d[i] = '0;
                    end
                end
            end
            S_ACCUM: begin
                if (iCalAbort) begin
                    state_d = S_IDLE;
                end else begin
                    if (in_win) begin
                        for (int unsigned i = 0; i < 3; i++) begin
                            if (pix[i] < min_q[i]) min_d[i] = pix[i];
                            if (pix[i] > max_q[i]) max_d[i] = pix[i];
                        end
                    end
                    if (marker) begin
                        if (cnt_q == FRAMES - 4'd1) begin
                            state_d = S_COMMIT;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                if (!iCalAbort) begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (tgt_q) thr_g_d = new_set;
                        else       thr_r_d = new_set;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            tgt_q   <= 1'b0;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                min_q[i] <= '0;
                max_q[i] <= '0;
            end
            thr_r_q <= DEF_R;
            thr_g_q <= DEF_G;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            min_q   <= min_d;
            max_q   <= max_d;
            thr_r_q <= thr_r_d;
            thr_g_q <= thr_g_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign oThreshR = thr_r_q;
    assign oThreshG = thr_g_q;
    assign oBusy    = busy_q;
    assign oDone    = done_q;
    assign oError   = err_q;

endmodule

// File: tb/tb_threshold_calibrator.sv
// Directed bench for threshold_calibrator: a default instance plus one whose
// window lies off-screen to exercise the empty-window error path.
`timescale 1ns/1ps
module tb_threshold_calibrator;

    localparam logic [47:0] DEF_R = 48'h0FFA_0891_A5F8;
    localparam logic [47:0] DEF_G = 48'h50F3_0878_0878;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] vx, vy;
    logic [9:0]  c1, c2, c3;
    logic        cal_start, cal_sel, cal_abort, start_nw;

    logic [47:0] thr_r, thr_g, nw_thr_r, nw_thr_g;
    logic        busy, done, err, in_win;
    logic        nw_busy, nw_done, nw_err, nw_in_win;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    threshold_calibrator dut (
        .VGA_CLK(clk), .RESET(rst), .VGA_X(vx), .VGA_Y(vy),
        .C1(c1), .C2(c2), .C3(c3),
        .iCalStart(cal_start), .iCalSel(cal_sel), .iCalAbort(cal_abort),
        .oThreshR(thr_r), .oThreshG(thr_g), .oBusy(busy), .oDone(done),
        .oError(err), .oInWindow(in_win)
    );

    threshold_calibrator #(.WIN_X0(11'd2000)) dut_nw (
        .VGA_CLK(clk), .RESET(rst), .VGA_X(vx), .VGA_Y(vy),
        .C1(c1), .C2(c2), .C3(c3),
        .iCalStart(start_nw), .iCalSel(cal_sel), .iCalAbort(cal_abort),
        .oThreshR(nw_thr_r), .oThreshG(nw_thr_g), .oBusy(nw_busy), .oDone(nw_done),
        .oError(nw_err), .oInWindow(nw_in_win)
    );

    task automatic check(input string tag, input logic [47:0] observed, input logic [47:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic marker();
        vx = 11'd1;
        vy = 11'd1;
        step();
        vx = 11'd0;
        vy = 11'd0;
    endtask

    task automatic window_pixels(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            vx = 11'(310 + i % 20);
            vy = 11'(230 + i / 20);
            c1 = {v, 2'b01};
            c2 = {v, 2'b10};
            c3 = {v, 2'b11};
            step();
        end
        vx = 11'd0;
        vy = 11'd0;
    endtask

    task automatic start_cal(input logic sel);
        cal_start = 1'b1;
        cal_sel   = sel;
        step();
        cal_start = 1'b0;
    endtask

    // Runs nine markers (arm + eight frames); state ends in COMMIT.
    // A second start pulse with sel=1 is injected after marker restart_at.
    task automatic calibrate_to_commit(input logic [7:0] v, input int restart_at);
        for (int k = 0; k < 9; k++) begin
            marker();
            if (k == restart_at) begin
                cal_start = 1'b1;
                cal_sel   = 1'b1;
                step();
                cal_start = 1'b0;
            end
            if (k < 8) window_pixels(v, 4);
        end
    endtask

    initial begin
        rst = 1'b1; vx = '0; vy = '0; c1 = '0; c2 = '0; c3 = '0;
        cal_start = 1'b0; cal_sel = 1'b0; cal_abort = 1'b0; start_nw = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_thr_r", thr_r, DEF_R);
        check("rst_thr_g", thr_g, DEF_G);
        check("rst_busy", {47'd0, busy}, 48'd0);
        check("rst_done", {47'd0, done}, 48'd0);
        check("rst_err", {47'd0, err}, 48'd0);

        // Window bounds, inclusive
        vx = 11'd310; vy = 11'd230; #1 check("win_tl", {47'd0, in_win}, 48'd1);
        vx = 11'd329; vy = 11'd249; #1 check("win_br", {47'd0, in_win}, 48'd1);
        vx = 11'd330; vy = 11'd240; #1 check("win_x_out", {47'd0, in_win}, 48'd0);
        vx = 11'd309; vy = 11'd240; #1 check("win_x_low", {47'd0, in_win}, 48'd0);
        vx = 11'd320; vy = 11'd250; #1 check("win_y_out", {47'd0, in_win}, 48'd0);
        vx = 11'd0; vy = 11'd0;

        // Constant pixel 100 into red: 92..108 per channel
        start_cal(1'b0);
        check("c_busy_wait", {47'd0, busy}, 48'd1);
        calibrate_to_commit(8'd100, -1);
        check("c_no_done_commit", {47'd0, done}, 48'd0);
        check("c_busy_commit", {47'd0, busy}, 48'd1);
        step();
        check("c_done", {47'd0, done}, 48'd1);
        check("c_busy_idle", {47'd0, busy}, 48'd0);
        check("c_thr_r", thr_r, 48'h5C6C_5C6C_5C6C);
        check("c_thr_g", thr_g, DEF_G);
        step();
        check("c_done_one_cycle", {47'd0, done}, 48'd0);

        // Ramp on channel 1 into green: saturates to 0..255
        start_cal(1'b1);
        marker();
        for (int v = 3; v <= 252; v++) begin
            vx = 11'(310 + (v - 3) % 20);
            vy = 11'(230 + (v - 3) / 20);
            c1 = {8'(v), 2'b11};
            c2 = {8'd100, 2'b10};
            c3 = {8'd100, 2'b01};
            step();
        end
        vx = 11'd0; vy = 11'd0;
        for (int k = 0; k < 8; k++) begin
            marker();
            if (k < 7) window_pixels(8'd100, 4);
        end
        step();
        check("r_done", {47'd0, done}, 48'd1);
        check("r_thr_g", thr_g, 48'h00FF_5C6C_5C6C);
        check("r_thr_r", thr_r, 48'h5C6C_5C6C_5C6C);

        // Off-screen window: error pulse, nothing written
        start_nw = 1'b1;
        cal_sel  = 1'b0;
        step();
        start_nw = 1'b0;
        calibrate_to_commit(8'd77, -1);
        step();
        check("nw_err", {47'd0, nw_err}, 48'd1);
        check("nw_done", {47'd0, nw_done}, 48'd0);
        check("nw_thr_r", nw_thr_r, DEF_R);
        check("nw_thr_g", nw_thr_g, DEF_G);
        check("nw_main_idle", {47'd0, busy}, 48'd0);
        step();
        check("nw_err_one_cycle", {47'd0, nw_err}, 48'd0);

        // Abort in frame 4 of accumulation
        start_cal(1'b0);
        for (int k = 0; k < 4; k++) begin
            marker();
            window_pixels(8'd50, 4);
        end
        cal_abort = 1'b1;
        step();
        cal_abort = 1'b0;
        check("a4_busy", {47'd0, busy}, 48'd0);
        check("a4_done", {47'd0, done}, 48'd0);
        check("a4_err", {47'd0, err}, 48'd0);
        for (int k = 0; k < 6; k++) marker();
        check("a4_still_idle", {47'd0, busy}, 48'd0);
        check("a4_thr_r", thr_r, 48'h5C6C_5C6C_5C6C);
        check("a4_thr_g", thr_g, 48'h00FF_5C6C_5C6C);

        // Abort in the commit cycle
        start_cal(1'b0);
        calibrate_to_commit(8'd50, -1);
        cal_abort = 1'b1;
        step();
        cal_abort = 1'b0;
        check("ac_busy", {47'd0, busy}, 48'd0);
        check("ac_done", {47'd0, done}, 48'd0);
        check("ac_err", {47'd0, err}, 48'd0);
        check("ac_thr_r", thr_r, 48'h5C6C_5C6C_5C6C);
        step();
        check("ac_done_later", {47'd0, done}, 48'd0);

        // Restart pulse toward green mid-accumulation is ignored
        start_cal(1'b0);
        calibrate_to_commit(8'd200, 3);
        step();
        check("rs_done", {47'd0, done}, 48'd1);
        check("rs_thr_r", thr_r, 48'hC0D0_C0D0_C0D0);
        check("rs_thr_g", thr_g, 48'h00FF_5C6C_5C6C);
        cal_sel = 1'b0;

        // Reset during commit
        start_cal(1'b1);
        calibrate_to_commit(8'd10, -1);
        check("rc_busy_commit", {47'd0, busy}, 48'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rc_thr_r", thr_r, DEF_R);
        check("rc_thr_g", thr_g, DEF_G);
        check("rc_done", {47'd0, done}, 48'd0);
        check("rc_busy", {47'd0, busy}, 48'd0);
        step();
        check("rc_done_later", {47'd0, done}, 48'd0);
        check("rc_thr_g_later", thr_g, DEF_G);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/threshold_calibrator.md
THRESHOLD_CALIBRATOR -- requirements
Module: threshold_calibrator

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- WIN_X0, 11'd310, left column of the sample window.
- WIN_Y0, 11'd230, top row of the sample window.
- WIN_SIZE, 11'd20, window edge length in pixels; the window is square.
- FRAMES, 4'd8, number of full frames accumulated per calibration; legal range 1..15.
- MARGIN, 8'd8, widening applied to each observed min and max.
- DEF_R, 48'h0FFA_0891_A5F8, red threshold set after reset; packed {C1LOW,C1HIGH,C2LOW,C2HIGH,C3LOW,C3HIGH}.
- DEF_G, 48'h50F3_0878_0878, green threshold set after reset; same packing.

REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- VGA_CLK, in, 1, the only clock.
- RESET, in, 1, synchronous, active-high.
- VGA_X, in, 11, current pixel column.
- VGA_Y, in, 11, current pixel row.
- C1, in, 10, pixel channel 1; only bits [9:2] are used.
- C2, in, 10, pixel channel 2; only bits [9:2] are used.
- C3, in, 10, pixel channel 3; only bits [9:2] are used.
- iCalStart, in, 1, pulse that requests a calibration.
- iCalSel, in, 1, target set: 0 = red, 1 = green.
- iCalAbort, in, 1, cancels a calibration in progress.
- oThreshR, out, 48, red threshold set, packed as DEF_R.
- oThreshG, out, 48, green threshold set, packed as DEF_G.
- oBusy, out, 1, high while a calibration is in progress.
- oDone, out, 1, one-cycle pulse on a successful commit.
- oError, out, 1, one-cycle pulse when no sample was taken.
- oInWindow, out, 1, combinational indicator that the current pixel is in the window; used by the overlay.

Function
REQ-003 SHALL define the frame marker as VGA_X==1 && VGA_Y==1, sampled on the VGA_CLK rising edge.
REQ-004 SHALL assert oInWindow = (VGA_X in [WIN_X0, WIN_X0+WIN_SIZE-1]) && (VGA_Y in [WIN_Y0, WIN_Y0+WIN_SIZE-1]), inclusive bounds, unsigned 11-bit compare.
REQ-005 SHALL implement the states IDLE, WAIT_FRAME, ACCUM and COMMIT.
REQ-006 SHALL transition IDLE -> WAIT_FRAME when iCalStart=1 and iCalAbort=0, latching iCalSel into the internal target register.
REQ-007 SHALL ignore iCalStart in any state other than IDLE; the target set is not re-latched.
REQ-008 SHALL transition WAIT_FRAME -> ACCUM on a frame marker, and on that edge:
- clear the frame counter to 0;
- set all three channel minimums to 8'hFF;
- set all three channel maximums to 8'h00.
REQ-009 SHALL, in ACCUM, update each channel's min/max with Cn[9:2] on every cycle with oInWindow=1.
REQ-010 SHALL, in ACCUM, increment the frame counter on each frame marker; the marker on which the counter equals FRAMES-1 SHALL move the state to COMMIT.
REQ-011 SHALL, in COMMIT, compute for each channel (all values saturating 8-bit):
- LOW = min > MARGIN ? min-MARGIN : 0;
- HIGH = max < 255-MARGIN ? max+MARGIN : 255.
REQ-012 SHALL, on the edge leaving COMMIT:
- write the packed LOW/HIGH set into the latched target only;
- leave the other set unchanged;
- pulse oDone for exactly one cycle;
- return to IDLE.
REQ-013 SHALL, if any channel has min > max at COMMIT (no in-window pixel seen):
- leave both sets unchanged;
- pulse oError instead of oDone;
- return to IDLE.
REQ-014 SHALL, on iCalAbort=1 in WAIT_FRAME, ACCUM or COMMIT:
- go to IDLE on the next edge;
- leave both sets unchanged;
- pulse neither oDone nor oError.
Abort SHALL have priority over every other transition, including the COMMIT write.
REQ-015 SHALL drive oBusy=1 exactly while the state is not IDLE.
REQ-016 SHALL make the new set and oDone/oError visible in the same cycle, two edges after the final frame marker.
REQ-017 SHALL register all outputs except oInWindow.

Reset
REQ-018 SHALL, when RESET=1 at a rising edge:
- set state IDLE, oBusy=0, oDone=0, oError=0;
- set oThreshR=DEF_R, oThreshG=DEF_G;
- clear the frame counter, min/max registers and target register.
REQ-019 SHALL give RESET priority over iCalStart, iCalAbort and any COMMIT in progress; a calibration interrupted by reset writes nothing.

Verification
REQ-020 SHALL cover: constant pixel C1=C2=C3=10'd400 (8-bit 100), iCalSel=0, FRAMES=8 -> oDone after the 9th marker + 2 cycles, oThreshR=48'h5C6C_5C6C_5C6C, oThreshG=DEF_G.
REQ-021 SHALL cover: in-window C1[9:2] ramps 3..252, iCalSel=1 -> oThreshG C1 LOW=0, HIGH=255 (saturation), oThreshR unchanged.
REQ-022 SHALL cover: WIN_X0=11'd2000 (window never visited) -> oError one-cycle pulse, oDone=0, both sets still default.
REQ-023 SHALL cover: iCalAbort in ACCUM frame 4, and separately iCalAbort in the COMMIT cycle -> IDLE next edge, no pulse, sets unchanged.
REQ-024 SHALL cover: iCalStart pulsed again with iCalSel=1 mid-ACCUM of a red calibration -> ignored, red set written, green unchanged.
REQ-025 SHALL cover: RESET asserted during COMMIT -> outputs equal defaults, oDone=0, oBusy=0 on the following cycle.
